// File: rtl/haar_database_server.sv
// Haar classifier database responder: on database_request, streams every stage's parameter words in parallel.
// Optional back-pressure input data_ready is added when HAAR_DB_STALL_EN is defined.
module haar_database_server #(
   parameter int NUM_STAGES               = 25,
   parameter int NUM_PARAM_PER_CLASSIFIER = 18,
   parameter int CLASSIFIERS_PER_TREE     = 3,
   parameter int MAX_TREES                = 8,
   parameter int DATA_WIDTH_12            = 12,
   parameter int DATA_WIDTH_16            = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 database_request,
`ifdef HAAR_DB_STALL_EN
   input  logic                                 data_ready,
`endif
   input  logic                                 cfg_wen,
   input  logic [7:0]                           cfg_stage,
   input  logic [DATA_WIDTH_12-1:0]             cfg_addr,
   input  logic [DATA_WIDTH_16-1:0]             cfg_data,
   input  logic                                 cfg_trees_wen,
   output logic [NUM_STAGES*DATA_WIDTH_16-1:0]  data,
   output logic [NUM_STAGES-1:0]                data_valid,
   output logic [NUM_STAGES*DATA_WIDTH_12-1:0]  index_tree,
   output logic [NUM_STAGES*DATA_WIDTH_12-1:0]  index_classifier,
   output logic [NUM_STAGES*DATA_WIDTH_12-1:0]  index_database,
   output logic [NUM_STAGES-1:0]                end_single_classifier,
   output logic [NUM_STAGES-1:0]                end_tree,
   output logic [NUM_STAGES-1:0]                end_all_classifier,
   output logic [NUM_STAGES-1:0]                end_database,
   output logic                                 o_busy
);
   localparam int DEPTH = MAX_TREES * CLASSIFIERS_PER_TREE * NUM_PARAM_PER_CLASSIFIER;
   localparam int AW    = $clog2(DEPTH);

   typedef logic [DATA_WIDTH_12-1:0] idx_t;
   typedef logic [DATA_WIDTH_16-1:0] word_t;
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   localparam idx_t       LAST_DB     = idx_t'(NUM_PARAM_PER_CLASSIFIER - 1);
   localparam idx_t       LAST_CLS    = idx_t'(CLASSIFIERS_PER_TREE - 1);
   localparam idx_t       TREE_LIMIT  = idx_t'(MAX_TREES);
   localparam idx_t       DEPTH_LIMIT = idx_t'(DEPTH);
   localparam logic [7:0] STAGE_LIMIT = 8'(NUM_STAGES);

   state_t state_q, state_d;
   logic   advance, clear, start, cfg_mem_wen;

   idx_t            tree_cnt [NUM_STAGES];
   logic [AW-1:0]   rd_addr  [NUM_STAGES];
   idx_t            cnt_db   [NUM_STAGES];
   idx_t            cnt_cls  [NUM_STAGES];
   idx_t            cnt_tree [NUM_STAGES];
   logic [NUM_STAGES-1:0] issue_done, issue_en, issue_last;

   // Stage-1 pipeline: attributes of the word whose memory read is in flight.
   logic [NUM_STAGES-1:0] p1_valid, p1_end_cls, p1_end_tree, p1_end_all;
   idx_t            p1_db    [NUM_STAGES];
   idx_t            p1_cls   [NUM_STAGES];
   idx_t            p1_tree  [NUM_STAGES];

   word_t           rd_data  [NUM_STAGES];
   word_t           data_r   [NUM_STAGES];
   idx_t            out_db   [NUM_STAGES];
   idx_t            out_cls  [NUM_STAGES];
   idx_t            out_tree [NUM_STAGES];

`ifdef HAAR_DB_STALL_EN
   assign advance = data_ready;
`else
   assign advance = 1'b1;
`endif

   assign o_busy      = (state_q != IDLE);
   assign clear       = (state_d == IDLE);
   assign start       = (state_q == IDLE) && (state_d == STREAM);
   assign cfg_mem_wen = (state_q == IDLE) && cfg_wen && (cfg_stage < STAGE_LIMIT) && (cfg_addr < DEPTH_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (database_request) state_d = STREAM;
         STREAM:  if (!database_request) state_d = IDLE;
                  else if (&end_database) state_d = DONE;
         DONE:    if (!database_request) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue_en   = '0;
      issue_last = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         issue_last[s] = (cnt_db[s] == LAST_DB) && (cnt_cls[s] == LAST_CLS) &&
                         (cnt_tree[s] == tree_cnt[s] - idx_t'(1));
         issue_en[s]   = (state_q == STREAM) && advance && !issue_done[s] && (tree_cnt[s] != '0);
      end
   end

   // Tree counts are cleared by reset only; counts above MAX_TREES saturate.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NUM_STAGES; s++) tree_cnt[s] <= '0;
      end else if ((state_q == IDLE) && cfg_trees_wen) begin
         for (int s = 0; s < NUM_STAGES; s++)
            if (cfg_stage == 8'(s))
               tree_cnt[s] <= (cfg_data[DATA_WIDTH_12-1:0] > TREE_LIMIT) ? TREE_LIMIT
                                                                        : cfg_data[DATA_WIDTH_12-1:0];
      end
   end

   // NOTE: state is updated with non-blocking assignments so all stages see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         issue_done            <= '0;
         p1_valid              <= '0;
         p1_end_cls            <= '0;
         p1_end_tree           <= '0;
         p1_end_all            <= '0;
         data_valid            <= '0;
         end_single_classifier <= '0;
         end_tree              <= '0;
         end_all_classifier    <= '0;
         end_database          <= '0;
         for (int s = 0; s < NUM_STAGES; s++) begin
            rd_addr[s]  <= '0;
            cnt_db[s]   <= '0;
            cnt_cls[s]  <= '0;
            cnt_tree[s] <= '0;
            p1_db[s]    <= '0;
            p1_cls[s]   <= '0;
            p1_tree[s]  <= '0;
            data_r[s]   <= '0;
            out_db[s]   <= '0;
            out_cls[s]  <= '0;
            out_tree[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (issue_en[s]) begin
               rd_addr[s] <= rd_addr[s] + AW'(1);
               if (issue_last[s]) issue_done[s] <= 1'b1;
               if (cnt_db[s] == LAST_DB) begin
                  cnt_db[s] <= '0;
                  if (cnt_cls[s] == LAST_CLS) begin
                     cnt_cls[s]  <= '0;
                     cnt_tree[s] <= cnt_tree[s] + idx_t'(1);
                  end else begin
                     cnt_cls[s] <= cnt_cls[s] + idx_t'(1);
                  end
               end else begin
                  cnt_db[s] <= cnt_db[s] + idx_t'(1);
               end
            end

            // A stage without trees is complete as soon as streaming begins.
            if ((start && (tree_cnt[s] == '0)) || (advance && data_valid[s] && end_all_classifier[s]))
               end_database[s] <= 1'b1;

            if (advance) begin
               p1_valid[s] <= issue_en[s];
               if (issue_en[s]) begin
                  p1_db[s]       <= cnt_db[s];
                  p1_cls[s]      <= cnt_cls[s];
                  p1_tree[s]     <= cnt_tree[s];
                  p1_end_cls[s]  <= (cnt_db[s] == LAST_DB);
                  p1_end_tree[s] <= (cnt_db[s] == LAST_DB) && (cnt_cls[s] == LAST_CLS);
                  p1_end_all[s]  <= issue_last[s];
               end

               data_valid[s]            <= p1_valid[s];
               end_single_classifier[s] <= p1_valid[s] && p1_end_cls[s];
               end_tree[s]              <= p1_valid[s] && p1_end_tree[s];
               end_all_classifier[s]    <= p1_valid[s] && p1_end_all[s];
               if (p1_valid[s]) begin
                  data_r[s]   <= rd_data[s];
                  out_db[s]   <= p1_db[s];
                  out_cls[s]  <= p1_cls[s];
                  out_tree[s] <= p1_tree[s];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
      word_t mem [DEPTH];
      word_t mem_q;

      // NOTE: the parameter memory is deliberately not reset; its contents must survive reset and stay RAM-mappable.
      always_ff @(posedge clk) begin
         if (cfg_mem_wen && (cfg_stage == 8'(g))) mem[cfg_addr[AW-1:0]] <= cfg_data;
         if (issue_en[g]) mem_q <= mem[rd_addr[g]];
      end

      assign rd_data[g] = mem_q;
      assign data[g*DATA_WIDTH_16 +: DATA_WIDTH_16]             = data_r[g];
      assign index_tree[g*DATA_WIDTH_12 +: DATA_WIDTH_12]       = out_tree[g];
      assign index_classifier[g*DATA_WIDTH_12 +: DATA_WIDTH_12] = out_cls[g];
      assign index_database[g*DATA_WIDTH_12 +: DATA_WIDTH_12]   = out_db[g];
   end

endmodule

// File: tb/tb_haar_database_server.sv
// Directed bench for haar_database_server: expected words are queued when a request is raised and
// popped as the DUT delivers them; stall coverage is compiled in when HAAR_DB_STALL_EN is defined.
module tb_haar_database_server;
   localparam int NS = 25;

   typedef struct packed {
      logic [15:0] data;
      logic [11:0] tree;
      logic [11:0] cls;
      logic [11:0] db;
      logic        es;
      logic        et;
      logic        ea;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset, database_request, cfg_wen, cfg_trees_wen, data_ready;
   logic [7:0]        cfg_stage;
   logic [11:0]       cfg_addr;
   logic [15:0]       cfg_data;
   logic [NS*16-1:0]  data;
   logic [NS-1:0]     data_valid;
   logic [NS*12-1:0]  index_tree, index_classifier, index_database;
   logic [NS-1:0]     end_single_classifier, end_tree, end_all_classifier, end_database;
   logic              o_busy;

   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   haar_database_server dut (
      .clk                   (clk),
      .reset                 (reset),
      .database_request      (database_request),
`ifdef HAAR_DB_STALL_EN
      .data_ready            (data_ready),
`endif
      .cfg_wen               (cfg_wen),
      .cfg_stage             (cfg_stage),
      .cfg_addr              (cfg_addr),
      .cfg_data              (cfg_data),
      .cfg_trees_wen         (cfg_trees_wen),
      .data                  (data),
      .data_valid            (data_valid),
      .index_tree            (index_tree),
      .index_classifier      (index_classifier),
      .index_database        (index_database),
      .end_single_classifier (end_single_classifier),
      .end_tree              (end_tree),
      .end_all_classifier    (end_all_classifier),
      .end_database          (end_database),
      .o_busy                (o_busy)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pat(input int s, input int k);
      return 16'(32'h0100 + k + s * 32'h0800);
   endfunction

   function automatic exp_t observe(input int s);
      exp_t w;
      w.data = data[s*16 +: 16];
      w.tree = index_tree[s*12 +: 12];
      w.cls  = index_classifier[s*12 +: 12];
      w.db   = index_database[s*12 +: 12];
      w.es   = end_single_classifier[s];
      w.et   = end_tree[s];
      w.ea   = end_all_classifier[s];
      return w;
   endfunction

   function automatic void push_words(input int s, input int count);
      exp_t w;
      for (int t = 0; t < count; t++)
         for (int c = 0; c < 3; c++)
            for (int d = 0; d < 18; d++) begin
               w.data = pat(s, (t * 3 + c) * 18 + d);
               w.tree = 12'(t);
               w.cls  = 12'(c);
               w.db   = 12'(d);
               w.es   = (d == 17);
               w.et   = (d == 17) && (c == 2);
               w.ea   = (d == 17) && (c == 2) && (t == count - 1);
               if (s == 0) q0.push_back(w);
               else        q1.push_back(w);
            end
   endfunction

   task automatic set_trees(input int s, input int v);
      cfg_trees_wen = 1'b1;
      cfg_stage     = 8'(s);
      cfg_data      = 16'(v);
      tick();
      cfg_trees_wen = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, data_valid, 0);
      check({tag, "_data"}, |data, 0);
      check({tag, "_index"}, {|index_tree, |index_classifier, |index_database}, 0);
      check({tag, "_ends"}, {|end_single_classifier, |end_tree, |end_all_classifier, |end_database}, 0);
      check({tag, "_busy"}, o_busy, 0);
   endtask

   // Caller has just raised database_request; the first tick is the edge that samples it.
   task automatic run_stream(input int n0, input int n1, input int abort_after,
                             input int stall_at, input int cfg_at, input int budget);
      int c, first0, stall_cnt, popped0, done_c, longest, exp_done, stray;
      int last_c[2];
      int rise_c[2];
      bit fin, poked;
      first0 = -1; stall_cnt = 0; popped0 = 0; done_c = -1; stray = 0;
      fin = 1'b0; poked = 1'b0;
      last_c = '{-1, -1};
      rise_c = '{-1, -1};
      for (c = 0; c < budget && !fin; c++) begin
         tick();
         cfg_wen       = 1'b0;
         cfg_trees_wen = 1'b0;
         data_ready    = 1'b1;
         if (stall_at >= 0 && popped0 == stall_at && stall_cnt < 5) begin
            data_ready = 1'b0;
            stall_cnt++;
         end
         if (cfg_at >= 0 && popped0 == cfg_at && !poked) begin
            cfg_wen = 1'b1; cfg_trees_wen = 1'b1;
            cfg_stage = 8'd0; cfg_addr = 12'd0; cfg_data = 16'h0003;
            poked = 1'b1;
         end
         if (!data_ready && q0.size() > 0) begin
            check("stall_valid_held", data_valid[0], 1);
            check("stall_word_held", observe(0), q0[0]);
         end
         if (data_valid[0] && data_ready) begin
            if (first0 < 0) first0 = c;
            if (q0.size() == 0) check("s0_unexpected_word", 1, 0);
            else                check("s0_word", observe(0), q0.pop_front());
            last_c[0] = c;
            popped0++;
         end
         if (data_valid[1] && data_ready) begin
            if (q1.size() == 0) check("s1_unexpected_word", 1, 0);
            else                check("s1_word", observe(1), q1.pop_front());
            last_c[1] = c;
         end
         if (|data_valid[NS-1:2]) stray++;
         for (int s = 0; s < 2; s++)
            if (end_database[s] && rise_c[s] < 0) rise_c[s] = c;
         if (abort_after >= 0 && popped0 == abort_after) begin
            database_request = 1'b0;
            tick();
            return;
         end
         if (&end_database) begin
            done_c = c;
            fin    = 1'b1;
         end
      end
      check("stream_completed", fin, 1);
      if (!fin) return;
      longest  = (n0 > n1) ? n0 : n1;
      exp_done = (longest == 0) ? 0 : 2 + longest + ((stall_at >= 0) ? 5 : 0);
      check("all_end_database_cycle", done_c, exp_done);
      if (n0 > 0) begin
         check("first_word_latency", first0, 2);
         check("s0_end_database_rise", rise_c[0], last_c[0] + 1);
      end
      if (n1 > 0) check("s1_end_database_rise", rise_c[1], last_c[1] + 1);
      check("queues_drained", q0.size() + q1.size(), 0);
      check("empty_stages_silent", stray, 0);
      tick();
      check("done_valid_low", data_valid, 0);
      check("done_busy", o_busy, 1);
      check("done_end_database", end_database, {NS{1'b1}});
   endtask

   task automatic finish_request(input string tag);
      database_request = 1'b0;
      tick();
      check_idle(tag);
   endtask

   initial begin
      reset = 1'b1; database_request = 1'b0; data_ready = 1'b1;
      cfg_wen = 1'b0; cfg_trees_wen = 1'b0; cfg_stage = '0; cfg_addr = '0; cfg_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_idle("reset");

      for (int s = 0; s < 2; s++)
         for (int k = 0; k < 432; k++) begin
            cfg_wen = 1'b1; cfg_stage = 8'(s); cfg_addr = 12'(k); cfg_data = pat(s, k);
            tick();
         end
      // Address 512 aliases word 0 in the low bits; it must be rejected.
      cfg_stage = 8'd0; cfg_addr = 12'd512; cfg_data = 16'hBEEF;
      tick();
      cfg_wen = 1'b0;

      // Single tree on stage 0
      set_trees(0, 1);
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, -1, -1, -1, 200);
      finish_request("t1_idle");

      // Stage 0 with two trees, stage 1 with one
      set_trees(0, 2);
      set_trees(1, 1);
      push_words(0, 2);
      push_words(1, 1);
      database_request = 1'b1;
      run_stream(108, 54, -1, -1, -1, 300);
      finish_request("t2_idle");

      // All stages empty
      set_trees(0, 0);
      set_trees(1, 0);
      database_request = 1'b1;
      run_stream(0, 0, -1, -1, -1, 20);
      finish_request("t3_idle");

      // Abort after 10 words, then a clean restart
      set_trees(0, 1);
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, 10, -1, -1, 200);
      check_idle("abort");
      q0.delete();
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, -1, -1, -1, 200);
      finish_request("t4_idle");

      // Config writes while streaming are ignored
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, -1, -1, 5, 200);
      finish_request("t5a_idle");
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, -1, -1, -1, 200);
      finish_request("t5b_idle");

      // Tree count 20 saturates at 8 trees
      set_trees(0, 20);
      push_words(0, 8);
      database_request = 1'b1;
      run_stream(432, 0, -1, -1, -1, 600);
      finish_request("t6_idle");

`ifdef HAAR_DB_STALL_EN
      // Five-cycle back-pressure in mid stage
      set_trees(0, 1);
      push_words(0, 1);
      database_request = 1'b1;
      run_stream(54, 0, -1, 20, -1, 200);
      finish_request("t7_idle");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
